// File: rtl/VX_ag_tcu_pkg.sv
// Shared constants, format IDs and micro-op payload for the AG tensor-core sequencer.
package VX_ag_tcu_pkg;

  localparam int unsigned AG_TCU_M_STEPS      = 2;
  localparam int unsigned AG_TCU_N_STEPS      = 4;
  localparam int unsigned AG_TCU_K_STEPS      = 4;
  localparam int unsigned AG_TCU_A_SUB_BLOCKS = 1;
  localparam int unsigned AG_TCU_B_SUB_BLOCKS = 2;
  localparam int unsigned AG_TCU_TAG_W        = 16;

  localparam int unsigned AG_TCU_MW   = (AG_TCU_M_STEPS > 1) ? $clog2(AG_TCU_M_STEPS) : 1;
  localparam int unsigned AG_TCU_NW   = (AG_TCU_N_STEPS > 1) ? $clog2(AG_TCU_N_STEPS) : 1;
  localparam int unsigned AG_TCU_KW   = (AG_TCU_K_STEPS > 1) ? $clog2(AG_TCU_K_STEPS) : 1;
  localparam int unsigned AG_TCU_BSW  = (AG_TCU_B_SUB_BLOCKS > 1) ? $clog2(AG_TCU_B_SUB_BLOCKS) : 1;
  localparam int unsigned AG_TCU_REGW = 5;
  localparam int unsigned AG_TCU_FMTW = 4;

  // Base register indices of the A, B and C fragments
  localparam logic [AG_TCU_REGW-1:0] AG_TCU_RA = 5'd0;
  localparam logic [AG_TCU_REGW-1:0] AG_TCU_RB = 5'd10;
  localparam logic [AG_TCU_REGW-1:0] AG_TCU_RC = 5'd24;

  localparam logic [AG_TCU_FMTW-1:0] FMT_FP32 = 4'd0;
  localparam logic [AG_TCU_FMTW-1:0] FMT_FP16 = 4'd1;
  localparam logic [AG_TCU_FMTW-1:0] FMT_BF16 = 4'd2;
  localparam logic [AG_TCU_FMTW-1:0] FMT_I32  = 4'd3;
  localparam logic [AG_TCU_FMTW-1:0] FMT_I8   = 4'd4;
  localparam logic [AG_TCU_FMTW-1:0] FMT_U8   = 4'd5;
  localparam logic [AG_TCU_FMTW-1:0] FMT_I4   = 4'd6;
  localparam logic [AG_TCU_FMTW-1:0] FMT_U4   = 4'd7;

  typedef struct packed {
    logic [AG_TCU_MW-1:0]    step_m;
    logic [AG_TCU_NW-1:0]    step_n;
    logic [AG_TCU_KW-1:0]    step_k;
    logic [AG_TCU_REGW-1:0]  ra;
    logic [AG_TCU_REGW-1:0]  rb;
    logic [AG_TCU_BSW-1:0]   b_sub;
    logic [AG_TCU_REGW-1:0]  rc;
    logic                    first;
    logic                    last;
    logic [AG_TCU_FMTW-1:0]  fmt_s;
    logic [AG_TCU_FMTW-1:0]  fmt_d;
    logic [AG_TCU_TAG_W-1:0] tag;
  } ag_tcu_uop_t;

  function automatic logic fmt_s_ok(input logic [AG_TCU_FMTW-1:0] f);
    return (f == FMT_FP16) || (f == FMT_BF16) || (f == FMT_I8) ||
           (f == FMT_U8)   || (f == FMT_I4)   || (f == FMT_U4);
  endfunction

  function automatic logic fmt_d_ok(input logic [AG_TCU_FMTW-1:0] f);
    return (f == FMT_FP32) || (f == FMT_I32);
  endfunction

endpackage

// File: rtl/ag_tcu_step_counter.sv
// Nested m/n/k step counter (k innermost); exposes the next value and a wrap flag.
module ag_tcu_step_counter #(
  parameter int unsigned M_STEPS = 2,
  parameter int unsigned N_STEPS = 4,
  parameter int unsigned K_STEPS = 4,
  parameter int unsigned MW      = 1,
  parameter int unsigned NW      = 2,
  parameter int unsigned KW      = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic [MW-1:0] nxt_m_c,
  output logic [NW-1:0] nxt_n_c,
  output logic [KW-1:0] nxt_k_c,
  output logic          wrap_c
);

  logic [MW-1:0] m_q, m_d;
  logic [NW-1:0] n_q, n_d;
  logic [KW-1:0] k_q, k_d;
  logic          m_last, n_last, k_last;

  assign m_last = (m_q == MW'(M_STEPS - 1));
  assign n_last = (n_q == NW'(N_STEPS - 1));
  assign k_last = (k_q == KW'(K_STEPS - 1));

  always_comb begin
    m_d = m_q;
    n_d = n_q;
    k_d = k_q;
    if (clear) begin
      m_d = '0;
      n_d = '0;
      k_d = '0;
    end else if (advance) begin
      if (k_last) begin
        k_d = '0;
        if (n_last) begin
          n_d = '0;
          m_d = m_last ? '0 : m_q + MW'(1);
        end else begin
          n_d = n_q + NW'(1);
        end
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
      k_q <= k_d;
    end
  end

  assign nxt_m_c = m_d;
  assign nxt_n_c = n_d;
  assign nxt_k_c = k_d;
  assign wrap_c  = advance & ~clear & m_last & n_last & k_last;

endmodule

// File: rtl/ag_tcu_uop_sequencer.sv
// Expands one WMMA instruction into M*N*K tensor-core micro-ops with backpressure.
// Optional AG_TCU_SEQ_PERF_EN adds busy/stall/instruction performance counters.
module ag_tcu_uop_sequencer
  import VX_ag_tcu_pkg::*;
#(
  parameter int unsigned M_STEPS      = AG_TCU_M_STEPS,
  parameter int unsigned N_STEPS      = AG_TCU_N_STEPS,
  parameter int unsigned K_STEPS      = AG_TCU_K_STEPS,
  parameter int unsigned A_SUB_BLOCKS = AG_TCU_A_SUB_BLOCKS,
  parameter int unsigned B_SUB_BLOCKS = AG_TCU_B_SUB_BLOCKS,
  parameter int unsigned TAG_W        = AG_TCU_TAG_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AG_TCU_FMTW-1:0] in_fmt_s,
  input  logic [AG_TCU_FMTW-1:0] in_fmt_d,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   uop_valid,
  input  logic                   uop_ready,
  output logic [AG_TCU_MW-1:0]   uop_step_m,
  output logic [AG_TCU_NW-1:0]   uop_step_n,
  output logic [AG_TCU_KW-1:0]   uop_step_k,
  output logic [AG_TCU_REGW-1:0] uop_ra,
  output logic [AG_TCU_REGW-1:0] uop_rb,
  output logic [AG_TCU_BSW-1:0]  uop_b_sub,
  output logic [AG_TCU_REGW-1:0] uop_rc,
  output logic                   uop_first,
  output logic                   uop_last,
  output logic [AG_TCU_FMTW-1:0] uop_fmt_s,
  output logic [AG_TCU_FMTW-1:0] uop_fmt_d,
  output logic [TAG_W-1:0]       uop_tag,
  output logic                   done,
  output logic                   fmt_err
`ifdef AG_TCU_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_busy_cycles,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_instrs
`endif
);

  typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_e;

  state_e      state_q, state_d;
  logic        uop_valid_q, uop_valid_d;
  logic        done_q, done_d;
  logic        fmt_err_q, fmt_err_d;
  ag_tcu_uop_t uop_q, uop_d;

  logic                 accept, fire, wrap;
  logic [AG_TCU_MW-1:0] nxt_m;
  logic [AG_TCU_NW-1:0] nxt_n;
  logic [AG_TCU_KW-1:0] nxt_k;

  function automatic ag_tcu_uop_t make_uop(
    input logic [AG_TCU_MW-1:0]    m,
    input logic [AG_TCU_NW-1:0]    n,
    input logic [AG_TCU_KW-1:0]    k,
    input logic [AG_TCU_FMTW-1:0]  fs,
    input logic [AG_TCU_FMTW-1:0]  fd,
    input logic [AG_TCU_TAG_W-1:0] tag
  );
    ag_tcu_uop_t u;
    u.step_m = m;
    u.step_n = n;
    u.step_k = k;
    u.ra     = AG_TCU_REGW'(32'(AG_TCU_RA) + (32'(m) / A_SUB_BLOCKS) * K_STEPS + 32'(k));
    u.rb     = AG_TCU_REGW'(32'(AG_TCU_RB) + (32'(n) / B_SUB_BLOCKS) * K_STEPS + 32'(k));
    u.b_sub  = AG_TCU_BSW'(32'(n) % B_SUB_BLOCKS);
    u.rc     = AG_TCU_REGW'(32'(AG_TCU_RC) + 32'(m) * N_STEPS + 32'(n));
    u.first  = (k == '0);
    u.last   = (k == AG_TCU_KW'(K_STEPS - 1));
    u.fmt_s  = fs;
    u.fmt_d  = fd;
    u.tag    = tag;
    return u;
  endfunction

  assign in_ready = (state_q == ST_IDLE) & ~flush;
  assign accept   = in_valid & in_ready;
  assign fire     = uop_valid_q & uop_ready;

  ag_tcu_step_counter #(
    .M_STEPS (M_STEPS),
    .N_STEPS (N_STEPS),
    .K_STEPS (K_STEPS),
    .MW      (AG_TCU_MW),
    .NW      (AG_TCU_NW),
    .KW      (AG_TCU_KW)
  ) u_step_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .advance (fire),
    .nxt_m_c (nxt_m),
    .nxt_n_c (nxt_n),
    .nxt_k_c (nxt_k),
    .wrap_c  (wrap)
  );

  // Next-state and output payload; uop_q only moves on acceptance or fire so it holds under stall
  always_comb begin
    state_d     = state_q;
    uop_valid_d = uop_valid_q;
    done_d      = 1'b0;
    fmt_err_d   = 1'b0;
    uop_d       = uop_q;
    if (flush) begin
      state_d     = ST_IDLE;
      uop_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            uop_d = make_uop(nxt_m, nxt_n, nxt_k, in_fmt_s, in_fmt_d, AG_TCU_TAG_W'(in_tag));
            if (fmt_s_ok(in_fmt_s) && fmt_d_ok(in_fmt_d)) begin
              state_d     = ST_ISSUE;
              uop_valid_d = 1'b1;
            end else begin
              fmt_err_d = 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (fire) begin
            if (wrap) begin
              state_d     = ST_IDLE;
              uop_valid_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              uop_d = make_uop(nxt_m, nxt_n, nxt_k, uop_q.fmt_s, uop_q.fmt_d, uop_q.tag);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      uop_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fmt_err_q   <= 1'b0;
      uop_q       <= '0;
    end else begin
      state_q     <= state_d;
      uop_valid_q <= uop_valid_d;
      done_q      <= done_d;
      fmt_err_q   <= fmt_err_d;
      uop_q       <= uop_d;
    end
  end

  assign uop_valid  = uop_valid_q;
  assign uop_step_m = uop_q.step_m;
  assign uop_step_n = uop_q.step_n;
  assign uop_step_k = uop_q.step_k;
  assign uop_ra     = uop_q.ra;
  assign uop_rb     = uop_q.rb;
  assign uop_b_sub  = uop_q.b_sub;
  assign uop_rc     = uop_q.rc;
  assign uop_first  = uop_q.first;
  assign uop_last   = uop_q.last;
  assign uop_fmt_s  = uop_q.fmt_s;
  assign uop_fmt_d  = uop_q.fmt_d;
  assign uop_tag    = TAG_W'(uop_q.tag);
  assign done       = done_q;
  assign fmt_err    = fmt_err_q;

`ifdef AG_TCU_SEQ_PERF_EN
  logic [31:0] busy_q, busy_d, stall_q, stall_d, instrs_q, instrs_d;

  // Free-running wrap-around counters, untouched by flush
  always_comb begin
    busy_d   = busy_q + 32'(state_q == ST_ISSUE);
    stall_d  = stall_q + 32'(uop_valid_q & ~uop_ready);
    instrs_d = instrs_q + 32'(done_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= '0;
      stall_q  <= '0;
      instrs_q <= '0;
    end else begin
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      instrs_q <= instrs_d;
    end
  end

  assign perf_busy_cycles  = busy_q;
  assign perf_stall_cycles = stall_q;
  assign perf_instrs       = instrs_q;
`endif

endmodule

// File: tb/tb_ag_tcu_uop_sequencer.sv
// Scoreboard bench for ag_tcu_uop_sequencer: stimulus pushes expected micro-ops, a monitor pops on every fire.
module tb_ag_tcu_uop_sequencer;
  import VX_ag_tcu_pkg::*;

  logic        clk, reset_n, flush, in_valid, in_ready, uop_valid, uop_ready;
  logic [3:0]  in_fmt_s, in_fmt_d, uop_fmt_s, uop_fmt_d;
  logic [15:0] in_tag, uop_tag;
  logic [0:0]  uop_step_m, uop_b_sub;
  logic [1:0]  uop_step_n, uop_step_k;
  logic [4:0]  uop_ra, uop_rb, uop_rc;
  logic        uop_first, uop_last, done, fmt_err;
`ifdef AG_TCU_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles, perf_instrs;
`endif

  ag_tcu_uop_sequencer dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d), .in_tag(in_tag),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_step_m(uop_step_m), .uop_step_n(uop_step_n), .uop_step_k(uop_step_k),
    .uop_ra(uop_ra), .uop_rb(uop_rb), .uop_b_sub(uop_b_sub), .uop_rc(uop_rc),
    .uop_first(uop_first), .uop_last(uop_last),
    .uop_fmt_s(uop_fmt_s), .uop_fmt_d(uop_fmt_d), .uop_tag(uop_tag),
    .done(done), .fmt_err(fmt_err)
`ifdef AG_TCU_SEQ_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles),
    .perf_instrs(perf_instrs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int fires = 0, done_cnt = 0, ferr_cnt = 0;
  logic rdy_rand = 1'b0;
  ag_tcu_uop_t exp_q[$];
  ag_tcu_uop_t act, held;
  logic prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  always_comb begin
    act.step_m = uop_step_m; act.step_n = uop_step_n; act.step_k = uop_step_k;
    act.ra = uop_ra; act.rb = uop_rb; act.b_sub = uop_b_sub; act.rc = uop_rc;
    act.first = uop_first; act.last = uop_last;
    act.fmt_s = uop_fmt_s; act.fmt_d = uop_fmt_d; act.tag = uop_tag;
  end

  // Datapath backpressure: always ready, or a coin flip each cycle
  always @(posedge clk) begin
    #1;
    uop_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stability under stall, and in-order compare on every fire
  always @(negedge clk) begin
    if (reset_n) begin
      if (uop_valid && prev_stall) chk("stall_stable", 64'(act), 64'(held));
      if (uop_valid && uop_ready) begin
        fires++;
        if (exp_q.size() == 0) chk("unexpected_uop", 64'(act), 64'(0));
        else chk($sformatf("uop_fire%0d", fires), 64'(act), 64'(exp_q.pop_front()));
      end
      prev_stall = uop_valid & ~uop_ready;
      held = act;
      if (done) done_cnt++;
      if (fmt_err) ferr_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic ag_tcu_uop_t exp_uop(input int i, input logic [3:0] fs, input logic [3:0] fd,
                                          input logic [15:0] tag);
    ag_tcu_uop_t u;
    int m, n, k;
    m = i / 16; n = (i / 4) % 4; k = i % 4;
    u.step_m = 1'(m); u.step_n = 2'(n); u.step_k = 2'(k);
    u.ra = 5'(m * 4 + k);
    u.rb = 5'(10 + (n / 2) * 4 + k);
    u.b_sub = 1'(n % 2);
    u.rc = 5'(24 + m * 4 + n);
    u.first = (k == 0); u.last = (k == 3);
    u.fmt_s = fs; u.fmt_d = fd; u.tag = tag;
    return u;
  endfunction

  task automatic push_instr(input logic [3:0] fs, input logic [3:0] fd, input logic [15:0] tag);
    for (int i = 0; i < 32; i++) exp_q.push_back(exp_uop(i, fs, fd, tag));
  endtask

  // Present one instruction when ready; returns at posedge+1 after acceptance
  task automatic issue(input logic [3:0] fs, input logic [3:0] fd, input logic [15:0] tag);
    int b = 0;
    @(posedge clk); #1;
    while (!in_ready && b < 100) begin @(posedge clk); #1; b++; end
    if (b >= 100) chk("in_ready_timeout", 64'(0), 64'(1));
    in_valid = 1'b1; in_fmt_s = fs; in_fmt_d = fd; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc, output int vcnt);
    cyc = 0; vcnt = 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      vcnt += int'(uop_valid);
    end
    if (!done) chk("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int cyc, vcnt, bf, bd, be;
    ag_tcu_uop_t c0, c31;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; uop_ready = 1'b1;
    in_fmt_s = '0; in_fmt_d = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_uop_valid", 64'(uop_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_fmt_err", 64'(fmt_err), 64'(0));
    chk("rst_payload", 64'(act), 64'(0));

    // Full sequence at full throughput, hand-computed first and last micro-ops
    c0  = '{step_m: 1'd0, step_n: 2'd0, step_k: 2'd0, ra: 5'd0, rb: 5'd10, b_sub: 1'd0, rc: 5'd24,
            first: 1'b1, last: 1'b0, fmt_s: FMT_FP16, fmt_d: FMT_FP32, tag: 16'hA5A5};
    c31 = '{step_m: 1'd1, step_n: 2'd3, step_k: 2'd3, ra: 5'd7, rb: 5'd17, b_sub: 1'd1, rc: 5'd31,
            first: 1'b0, last: 1'b1, fmt_s: FMT_FP16, fmt_d: FMT_FP32, tag: 16'hA5A5};
    bf = fires; bd = done_cnt;
    for (int i = 0; i < 32; i++)
      exp_q.push_back(i == 0 ? c0 : (i == 31 ? c31 : exp_uop(i, FMT_FP16, FMT_FP32, 16'hA5A5)));
    issue(FMT_FP16, FMT_FP32, 16'hA5A5);
    chk("first_uop_latency", 64'(uop_valid), 64'(1));
    wait_done(200, cyc, vcnt);
    chk("t1_valid_cycles", 64'(vcnt), 64'(32));
    chk("t1_done_latency", 64'(cyc), 64'(33));
    chk("t1_in_ready_at_done", 64'(in_ready), 64'(1));
    chk("t1_valid_low_at_done", 64'(uop_valid), 64'(0));
    repeat (3) @(negedge clk);
    #1;
    chk("t1_fires", 64'(fires - bf), 64'(32));
    chk("t1_done_once", 64'(done_cnt - bd), 64'(1));

    // Random backpressure
    bf = fires; bd = done_cnt;
    rdy_rand = 1'b1;
    push_instr(FMT_BF16, FMT_FP32, 16'h1234);
    issue(FMT_BF16, FMT_FP32, 16'h1234);
    wait_done(600, cyc, vcnt);
    rdy_rand = 1'b0;
    #1;
    chk("t2_fires", 64'(fires - bf), 64'(32));
    chk("t2_done", 64'(done_cnt - bd), 64'(1));
    chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));

    // Back-to-back with in_valid held
    bd = done_cnt;
    @(posedge clk); #1;
    push_instr(FMT_I8, FMT_I32, 16'h0001);
    push_instr(FMT_I8, FMT_I32, 16'h0002);
    in_valid = 1'b1; in_fmt_s = FMT_I8; in_fmt_d = FMT_I32; in_tag = 16'h0001;
    @(posedge clk); #1;
    in_tag = 16'h0002;
    wait_done(200, cyc, vcnt);
    chk("t3_bubble_valid", 64'(uop_valid), 64'(0));
    chk("t3_ready_at_done", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3_second_started", 64'(uop_valid), 64'(1));
    wait_done(200, cyc, vcnt);
    #1;
    chk("t3_done_twice", 64'(done_cnt - bd), 64'(2));
    chk("t3_queue_empty", 64'(exp_q.size()), 64'(0));

    // Unsupported formats: destination FP16, then source FP32
    be = ferr_cnt; bf = fires;
    issue(FMT_FP16, FMT_FP16, 16'hBEEF);
    chk("t4_fmt_err_pulse", 64'(fmt_err), 64'(1));
    chk("t4_no_uop", 64'(uop_valid), 64'(0));
    chk("t4_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    chk("t4_fmt_err_clears", 64'(fmt_err), 64'(0));
    issue(FMT_FP32, FMT_FP32, 16'hBEEF);
    chk("t4_src_fmt_err", 64'(fmt_err), 64'(1));
    repeat (2) @(posedge clk); #1;
    chk("t4_err_count", 64'(ferr_cnt - be), 64'(2));
    chk("t4_zero_fires", 64'(fires - bf), 64'(0));

    // Flush after the 10th fire
    bf = fires; bd = done_cnt;
    push_instr(FMT_U4, FMT_I32, 16'h0F0F);
    issue(FMT_U4, FMT_I32, 16'h0F0F);
    cyc = 0;
    while ((fires - bf) < 10 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t5_valid_low", 64'(uop_valid), 64'(0));
    chk("t5_delivered", 64'(32 - exp_q.size()), 64'(11));
    exp_q.delete();
    repeat (4) @(posedge clk); #1;
    chk("t5_no_done", 64'(done_cnt - bd), 64'(0));
    push_instr(FMT_U8, FMT_I32, 16'h0F10);
    issue(FMT_U8, FMT_I32, 16'h0F10);
    wait_done(200, cyc, vcnt);
    #1;
    chk("t5_restart_complete", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset in the middle of ISSUE
    push_instr(FMT_I4, FMT_I32, 16'h7777);
    issue(FMT_I4, FMT_I32, 16'h7777);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_valid_drop", 64'(uop_valid), 64'(0));
    chk("t6_payload_zero", 64'(act), 64'(0));
`ifdef AG_TCU_SEQ_PERF_EN
    chk("t6_perf_busy", 64'(perf_busy_cycles), 64'(0));
    chk("t6_perf_stall", 64'(perf_stall_cycles), 64'(0));
    chk("t6_perf_instrs", 64'(perf_instrs), 64'(0));
`endif
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    push_instr(FMT_I8, FMT_FP32, 16'h0042);
    issue(FMT_I8, FMT_FP32, 16'h0042);
    wait_done(200, cyc, vcnt);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ag_tcu_uop_sequencer.md
Name: ag_tcu_uop_sequencer

Overview:
- Expands one accepted WMMA instruction into AG_TCU_UOPS micro-ops for the AG tensor-core datapath.
- Each micro-op carries its step indices, its A/B/C register indices and first/last accumulate flags.
- Sits between the AG TCU dispatch stage and the dot-product datapath; the datapath provides backpressure on every micro-op.

Parameters:
- M_STEPS, 2, m-step count (equals AG_TCU_M_STEPS)
- N_STEPS, 4, n-step count (equals AG_TCU_N_STEPS)
- K_STEPS, 4, k-step count (equals AG_TCU_K_STEPS)
- A_SUB_BLOCKS, 1, A micro-tiles per register (equals AG_TCU_A_SUB_BLOCKS)
- B_SUB_BLOCKS, 2, B micro-tiles per register (equals AG_TCU_B_SUB_BLOCKS)
- TAG_W, 16, opaque instruction tag width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the current sequence
- in_valid  in  1  WMMA instruction valid
- in_ready  out  1  sequencer can accept an instruction
- in_fmt_s  in  4  source format ID
- in_fmt_d  in  4  destination format ID
- in_tag  in  TAG_W  tag passed through to every micro-op
- uop_valid  out  1  micro-op valid
- uop_ready  in  1  datapath accepts the micro-op
- uop_step_m  out  clog2(M_STEPS)  m index
- uop_step_n  out  clog2(N_STEPS)  n index
- uop_step_k  out  clog2(K_STEPS)  k index
- uop_ra  out  5  A register index
- uop_rb  out  5  B register index
- uop_b_sub  out  max(1,clog2(B_SUB_BLOCKS))  B sub-block select
- uop_rc  out  5  C register index
- uop_first  out  1  k==0: accumulate from C register
- uop_last  out  1  k==K_STEPS-1: write result back
- uop_fmt_s, uop_fmt_d  out  4 each  latched formats
- uop_tag  out  TAG_W  latched tag
- done  out  1  one-cycle pulse when the last micro-op fires
- fmt_err  out  1  one-cycle pulse when an unsupported format is rejected

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; all counters 0; uop_valid=0; done=0; fmt_err=0; latched fields=0.
- in_ready = (state==IDLE) & ~flush.
- States:
  - IDLE: on in_valid & in_ready, latch the fields and clear the counters.
    - If fmt_s ∉ {FP16,BF16,I8,U8,I4,U4} or fmt_d ∉ {FP32,I32}: pulse fmt_err next cycle and stay in IDLE; no micro-ops issue.
    - Otherwise go to ISSUE.
  - ISSUE: uop_valid=1. On fire (uop_valid & uop_ready), advance the counters in order k innermost, then n, then m.
    - On fire with m,n,k all at maximum: pulse done the next cycle, drop uop_valid and go to IDLE.
- Latency and throughput:
  - First micro-op is valid the cycle after acceptance.
  - With uop_ready held high, one micro-op per cycle: 32 micro-ops in 32 cycles.
  - in_ready returns the cycle after done's fire cycle, giving one bubble between instructions.
- Stability: all uop_* outputs are registered and must stay stable while uop_valid & ~uop_ready.
- Index arithmetic (5-bit, no wrap is possible at the default parameters):
  - ra = RA + (m/A_SUB_BLOCKS)*K_STEPS + k
  - rb = RB + (n/B_SUB_BLOCKS)*K_STEPS + k, with b_sub = n % B_SUB_BLOCKS
  - rc = RC + m*N_STEPS + n
  - RA=0, RB=10, RC=24 (the values for the default configuration)
- flush:
  - In any state, go to IDLE next cycle and deassert uop_valid next cycle; no done pulse.
  - A micro-op firing in the flush cycle still counts as delivered.
  - flush overrides in_valid.
- Reset asserted mid-sequence: immediate return to the reset state; the partial sequence is lost.

Optional Feature:
- Macro: AG_TCU_SEQ_PERF_EN.
- When defined, adds three outputs:
  - perf_busy_cycles (32-bit): counts cycles in ISSUE.
  - perf_stall_cycles (32-bit): counts cycles with uop_valid & ~uop_ready.
  - perf_instrs (32-bit): counts done pulses.
- All three reset to 0, wrap modulo 2^32 and are unaffected by flush.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- In VX_ag_tcu_pkg: step counts, sub-block counts, RA/RB/RC, format IDs, and a packed ag_tcu_uop_t struct of the uop_* fields.
- Sequencer FSM states as an enum local to the module.
- One sub-module: ag_tcu_step_counter, a nested m/n/k counter with advance input and wrap/last outputs.

Test Plan:
- fp16→fp32 instruction, uop_ready=1 → 32 micro-ops on consecutive cycles:
  - micro-op 0: m=0,n=0,k=0, ra=0, rb=10, b_sub=0, rc=24, first=1.
  - micro-op 31: m=1,n=3,k=3, ra=7, rb=17, b_sub=1, rc=31, last=1.
  - done pulses once.
- Random uop_ready at 50% → outputs hold stable through stalls; exactly 32 fires in order; the tag is constant throughout.
- Back-to-back instructions with in_valid held → second accepted exactly one cycle after the first's done; no overlap of micro-ops.
- fmt_d=FP16 → fmt_err pulse, zero micro-ops, in_ready high again 1 cycle later.
- flush after the 10th fire → uop_valid low the next cycle, no done; a new instruction then restarts at m=n=k=0.
- reset_n dropped mid-ISSUE, asynchronously between clock edges → uop_valid low immediately; with AG_TCU_SEQ_PERF_EN defined, all counters read 0.
